// File: rtl/stall_ctrl_if.sv
// Hazard-unit signal bundle between the pipeline datapath and stall_ctrl.
// The slave modport is the controller's view; the master drives the D/E/M stage fields.
interface stall_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_md;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        F_WE;
    logic        D_WE;
    logic        E_WE;
    logic        E_clr;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md,
        input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        output F_WE, D_WE, E_WE, E_clr, stall, md_busy, stall_cnt
    );

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md,
        output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        input  F_WE, D_WE, E_WE, E_clr, stall, md_busy, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// Five-stage pipeline hazard/stall controller: Tuse/Tnew data hazards,
// multiply/divide busy-window sequencing and a saturating stall counter.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic          clk,
    input logic          reset,
    stall_ctrl_if.slave  hz
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CW_RAW     = $clog2(MAX_CYCLES + 1);
    localparam int unsigned CW         = (CW_RAW < 4) ? 4 : CW_RAW;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } md_state_t;

    md_state_t   r_md_state;
    logic [CW-1:0] r_md_cnt;
    logic [31:0] r_stall_cnt;

    logic        w_stall_rs;
    logic        w_stall_rt;
    logic        w_stall_md;
    logic        w_stall;
    logic        w_md_busy;
    logic [CW-1:0] w_md_load;

    // Tuse of 3 exceeds any Tnew, and Tnew of 0 is always forwarded, so neither stalls.
    always_comb begin
        w_stall_rs = (hz.D_rs != 5'd0) &&
                     (((hz.D_rs == hz.E_wa) && (hz.D_tuse_rs < hz.E_tnew)) ||
                      ((hz.D_rs == hz.M_wa) && (hz.D_tuse_rs < hz.M_tnew)));
        w_stall_rt = (hz.D_rt != 5'd0) &&
                     (((hz.D_rt == hz.E_wa) && (hz.D_tuse_rt < hz.E_tnew)) ||
                      ((hz.D_rt == hz.M_wa) && (hz.D_tuse_rt < hz.M_tnew)));
    end

    assign w_md_busy  = (r_md_state == S_BUSY);
    assign w_stall_md = hz.D_md && (hz.E_md_start || w_md_busy);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    assign w_md_load  = hz.E_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    assign hz.stall     = w_stall;
    assign hz.F_WE      = ~w_stall;
    assign hz.D_WE      = ~w_stall;
    assign hz.E_WE      = 1'b1;
    assign hz.E_clr     = w_stall;
    assign hz.md_busy   = w_md_busy;
    assign hz.stall_cnt = r_stall_cnt;

    // State mirrors md_cnt != 0 so md_busy comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_state <= S_IDLE;
            r_md_cnt   <= '0;
        end else if (hz.E_md_start) begin
            r_md_cnt   <= w_md_load;
            r_md_state <= (w_md_load != '0) ? S_BUSY : S_IDLE;
        end else begin
            case (r_md_state)
                S_BUSY: begin
                    r_md_cnt   <= r_md_cnt - CW'(1);
                    r_md_state <= (r_md_cnt == CW'(1)) ? S_IDLE : S_BUSY;
                end
                default: begin
                    r_md_cnt   <= '0;
                    r_md_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
